// File: rtl/alu_pkg.sv
// Shared constants for the alu execute pipeline: datapath width and opcode map.
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

endpackage

// File: rtl/alu_exec_pipe_core.sv
// Combinational 8-bit alu core: 16 opcodes, carry from the adder, divide-by-zero flag.
module alu_exec_pipe_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             dz
);

    logic [WIDTH:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[WIDTH];

    always_comb begin
        result = '0;
        dz     = 1'b0;
        case (sel)
            OP_ADD:  result = sum[WIDTH-1:0];
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV: begin
                // Divide by zero saturates to all ones and raises the flag.
                if (b == '0) begin
                    result = '1;
                    dz     = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            OP_SHL:  result = a << 1;
            OP_SHR:  result = a >> 1;
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  result = {a[0], a[WIDTH-1:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage issue/execute wrapper around the alu core with valid/ready on both sides,
// accumulator chaining and a completed-operation counter.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_sel,
    input  logic             in_use_acc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_dz,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_count
);

    if (WIDTH != alu_pkg::WIDTH) begin : g_width_check
        $error("alu_exec_pipe: WIDTH must be 8 to match the alu core");
    end

    logic             x_valid;
    logic [WIDTH-1:0] x_a;
    logic [WIDTH-1:0] x_b;
    logic [3:0]       x_sel;
    logic             x_use_acc;
    logic [TAG_W-1:0] x_tag;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_dz;
    logic             w_load;
    logic             accept;
    logic             drain;

    assign w_load   = x_valid && (!out_valid || out_ready);
    assign in_ready = !x_valid || w_load;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign a_eff    = x_use_acc ? acc : x_a;

    alu_exec_pipe_core u_core (
        .a      (a_eff),
        .b      (x_b),
        .sel    (x_sel),
        .result (alu_result),
        .carry  (alu_carry),
        .dz     (alu_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid   <= 1'b0;
            x_a       <= '0;
            x_b       <= '0;
            x_sel     <= '0;
            x_use_acc <= 1'b0;
            x_tag     <= '0;
        end else if (accept) begin
            x_valid   <= 1'b1;
            x_a       <= in_a;
            x_b       <= in_b;
            x_sel     <= in_sel;
            x_use_acc <= in_use_acc;
            x_tag     <= in_tag;
        end else if (w_load) begin
            x_valid   <= 1'b0;
        end
    end

    // acc follows the output register so a chained op sees its predecessor's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_zero   <= 1'b0;
            out_dz     <= 1'b0;
            out_tag    <= '0;
            acc        <= '0;
        end else if (w_load) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_carry  <= alu_carry && (x_sel == OP_ADD);
            out_zero   <= (alu_result == '0);
            out_dz     <= alu_dz;
            out_tag    <= x_tag;
            acc        <= alu_result;
        end else if (drain) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (drain) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Self-checking bench for alu_exec_pipe: directed steps plus random traffic against a queue model.
module tb_alu_exec_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_sel;
    logic        in_use_acc;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_carry, out_zero, out_dz;
    logic [7:0]  out_result;
    logic [3:0]  out_tag;
    logic [15:0] op_count;

    logic        in_ready2, out_valid2, out_carry2, out_zero2, out_dz2;
    logic [7:0]  out_result2;
    logic [3:0]  out_tag2;
    logic [1:0]  op_count2;

    always #5 clk = ~clk;

    alu_exec_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_use_acc(in_use_acc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_dz(out_dz), .out_tag(out_tag),
        .op_count(op_count)
    );

    alu_exec_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_use_acc(in_use_acc), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_carry(out_carry2), .out_zero(out_zero2), .out_dz(out_dz2), .out_tag(out_tag2),
        .op_count(op_count2)
    );

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       dz;
        logic [3:0] tag;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  macc;
    logic [31:0] cnt;
    bit          fired;
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] sel, input logic [3:0] tag);
        exp_t e;
        int   ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        e.c = 1'b0;
        e.dz = 1'b0;
        case (sel)
            4'd0:  begin r = ai + bi; e.c = (r > 255); end
            4'd1:  r = ai - bi;
            4'd2:  r = ai * bi;
            4'd3:  if (bi == 0) begin r = 255; e.dz = 1'b1; end else r = ai / bi;
            4'd4:  r = ai * 2;
            4'd5:  r = ai / 2;
            4'd6:  r = (ai * 2) % 256 + ai / 128;
            4'd7:  r = ai / 2 + (ai % 2) * 128;
            4'd8:  r = ai & bi;
            4'd9:  r = ai | bi;
            4'd10: r = ai ^ bi;
            4'd11: r = 255 - (ai | bi);
            4'd12: r = 255 - (ai & bi);
            4'd13: r = 255 - (ai ^ bi);
            4'd14: r = (ai > bi) ? 1 : 0;
            default: r = (ai == bi) ? 1 : 0;
        endcase
        e.r = 8'(r & 255);
        e.z = (e.r == 8'h00);
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                          input logic use_acc, input logic [3:0] tag);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_sel     = sel;
        in_use_acc = use_acc;
        in_tag     = tag;
    endtask

    task automatic set_rand_op();
        set_op(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
    endtask

    // Called at a falling edge with inputs already driven; scores this cycle, then advances.
    task automatic tick();
        exp_t e;
        #1;
        fired = 1'b0;
        chk("op_count", 32'(op_count), cnt & 32'hFFFF);
        chk("op_count_w2", 32'(op_count2), cnt & 32'h3);
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'h0);
            end else begin
                e = q[0];
                chk("out_result", 32'(out_result), 32'(e.r));
                chk("out_carry", 32'(out_carry), 32'(e.c));
                chk("out_zero", 32'(out_zero), 32'(e.z));
                chk("out_dz", 32'(out_dz), 32'(e.dz));
                chk("out_tag", 32'(out_tag), 32'(e.tag));
                if (out_ready) begin
                    void'(q.pop_front());
                    cnt++;
                end
            end
        end
        if (in_valid && in_ready) begin
            e = model(in_use_acc ? macc : in_a, in_b, in_sel, in_tag);
            q.push_back(e);
            macc = e.r;
            fired = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] bp_a [3];
        logic [7:0] bp_b [3];
        int k;

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; in_use_acc = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        macc = '0; cnt = '0;

        // Reset held with random inputs
        repeat (4) begin
            @(negedge clk);
            set_rand_op();
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_op_count", 32'(op_count), 32'h0);
            chk("rst_out_result", 32'(out_result), 32'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // ADD with carry, two cycles to output
        set_op(8'hF0, 8'h20, 4'd0, 1'b0, 4'd3);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("add_valid", 32'(out_valid), 32'h1);
        chk("add_result", 32'(out_result), 32'h10);
        chk("add_carry", 32'(out_carry), 32'h1);
        chk("add_zero", 32'(out_zero), 32'h0);
        chk("add_tag", 32'(out_tag), 32'h3);
        tick();
        #1;
        chk("add_op_count", 32'(op_count), 32'h1);

        // DIV by zero, then SUB to zero
        set_op(8'h10, 8'h00, 4'd3, 1'b0, 4'd5);
        tick();
        set_op(8'h05, 8'h05, 4'd1, 1'b0, 4'd6);
        tick();
        #1;
        chk("div0_result", 32'(out_result), 32'hFF);
        chk("div0_dz", 32'(out_dz), 32'h1);
        chk("div0_carry", 32'(out_carry), 32'h0);
        in_valid = 1'b0;
        tick();
        #1;
        chk("sub_result", 32'(out_result), 32'h00);
        chk("sub_zero", 32'(out_zero), 32'h1);
        tick();

        // Accumulator chain, back to back
        set_op(8'h05, 8'h03, 4'd0, 1'b0, 4'd1);
        tick();
        set_op(8'h00, 8'h02, 4'd0, 1'b1, 4'd2);
        tick();
        #1;
        chk("chain0", 32'(out_result), 32'h08);
        set_op(8'h00, 8'h00, 4'd4, 1'b1, 4'd3);
        tick();
        #1;
        chk("chain1", 32'(out_result), 32'h0A);
        in_valid = 1'b0;
        tick();
        #1;
        chk("chain2", 32'(out_result), 32'h14);
        tick();

        // Backpressure: three ops offered, only two fit
        for (int i = 0; i < 3; i++) begin
            bp_a[i] = 8'($urandom);
            bp_b[i] = 8'($urandom);
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            if (k < 3) set_op(bp_a[k], bp_b[k], 4'(k + 8), 1'b0, 4'(k + 10));
            else in_valid = 1'b0;
            tick();
            if (fired) k++;
        end
        chk("bp_accepted", 32'(k), 32'd2);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (k < 3) set_op(bp_a[k], bp_b[k], 4'(k + 8), 1'b0, 4'(k + 10));
            else in_valid = 1'b0;
            tick();
            if (fired) k++;
        end
        chk("bp_all_accepted", 32'(k), 32'd3);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        set_rand_op();
        tick();
        set_rand_op();
        tick();
        in_valid = 1'b0;
        #2;
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_op_count", 32'(op_count), 32'h0);
        q.delete();
        macc = '0;
        cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_op(8'h55, 8'h07, 4'd0, 1'b1, 4'd9);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("acc_after_reset", 32'(out_result), 32'h07);
        for (int i = 0; i < 4; i++) begin
            set_rand_op();
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("w2_count_wrap", 32'(op_count2), 32'h1);

        // Random traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            set_rand_op();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("final_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
